// File: rtl/ps2_poly_note_decoder.sv
// PS/2 set-2 scan-code parser driving a polyphonic note allocator with
// octave/amplitude control keys. All outputs are registered on CLOCK_50.
module ps2_poly_note_decoder #(
   parameter int NUM_VOICES  = 4,
   parameter int OCT_WIDTH   = 3,
   parameter int OCT_DEFAULT = 4,
   parameter int AMP_WIDTH   = 4,
   parameter int AMP_DEFAULT = 8,
   localparam int EV_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                            CLOCK_50,
   input  logic                            KEY,
   input  logic [7:0]                      scan_code,
   input  logic                            scan_valid,
   output logic [NUM_VOICES-1:0]           voice_active,
   output logic [4*NUM_VOICES-1:0]         voice_note,
   output logic [OCT_WIDTH*NUM_VOICES-1:0] voice_octave,
   output logic [OCT_WIDTH-1:0]            octave,
   output logic [AMP_WIDTH-1:0]            amplitude,
   output logic                            event_valid,
   output logic                            event_on,
   output logic [EV_W-1:0]                 event_voice,
   output logic                            overflow,
   output logic [1:0]                      state_dbg
);

   // Handshake: a byte is taken on every rising edge where scan_valid=1;
   // there is no back-pressure, so the parser must accept one byte per cycle.

   typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

   localparam logic [7:0] CODE_BRK = 8'hF0;
   localparam logic [7:0] CODE_EXT = 8'hE0;

   state_t       state;
   logic [3:0]   ctrl_held;
   logic         code_is_note;
   logic [3:0]   code_note;
   logic         code_is_ctrl;
   logic [1:0]   code_ctrl;
   logic         held_hit;
   logic [EV_W-1:0] held_idx;
   logic         free_found;
   logic [EV_W-1:0] free_idx;

   assign state_dbg = state;

   always_comb begin
      code_is_note = 1'b0;
      code_note    = 4'd0;
      code_is_ctrl = 1'b0;
      code_ctrl    = 2'd0;
      case (scan_code)
         8'h1C: begin code_is_note = 1'b1; code_note = 4'd0;  end
         8'h1D: begin code_is_note = 1'b1; code_note = 4'd1;  end
         8'h1B: begin code_is_note = 1'b1; code_note = 4'd2;  end
         8'h24: begin code_is_note = 1'b1; code_note = 4'd3;  end
         8'h23: begin code_is_note = 1'b1; code_note = 4'd4;  end
         8'h2B: begin code_is_note = 1'b1; code_note = 4'd5;  end
         8'h2C: begin code_is_note = 1'b1; code_note = 4'd6;  end
         8'h34: begin code_is_note = 1'b1; code_note = 4'd7;  end
         8'h35: begin code_is_note = 1'b1; code_note = 4'd8;  end
         8'h33: begin code_is_note = 1'b1; code_note = 4'd9;  end
         8'h3C: begin code_is_note = 1'b1; code_note = 4'd10; end
         8'h3B: begin code_is_note = 1'b1; code_note = 4'd11; end
         8'h1A: begin code_is_ctrl = 1'b1; code_ctrl = 2'd0;  end
         8'h22: begin code_is_ctrl = 1'b1; code_ctrl = 2'd1;  end
         8'h16: begin code_is_ctrl = 1'b1; code_ctrl = 2'd2;  end
         8'h1E: begin code_is_ctrl = 1'b1; code_ctrl = 2'd3;  end
         default: ;
      endcase
   end

   // Descending scan so the lowest matching index is the one that sticks.
   always_comb begin
      held_hit   = 1'b0;
      held_idx   = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (!voice_active[i]) begin
            free_found = 1'b1;
            free_idx   = EV_W'(i);
         end
         if (voice_active[i] && (voice_note[4*i +: 4] == code_note)) begin
            held_hit = 1'b1;
            held_idx = EV_W'(i);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge KEY) begin
      if (!KEY) begin
         state        <= S_IDLE;
         voice_active <= '0;
         voice_note   <= '0;
         voice_octave <= '0;
         octave       <= OCT_WIDTH'(OCT_DEFAULT);
         amplitude    <= AMP_WIDTH'(AMP_DEFAULT);
         ctrl_held    <= '0;
         event_valid  <= 1'b0;
         event_on     <= 1'b0;
         event_voice  <= '0;
         overflow     <= 1'b0;
      end else begin
         event_valid <= 1'b0;
         overflow    <= 1'b0;
         if (scan_valid) begin
            case (state)
               S_IDLE: begin
                  if (scan_code == CODE_BRK) begin
                     state <= S_BRK;
                  end else if (scan_code == CODE_EXT) begin
                     state <= S_EXT;
                  end else if (code_is_note) begin
                     // A repeat of a held semitone is typematic and is ignored.
                     if (!held_hit) begin
                        if (free_found) begin
                           voice_active[free_idx]                    <= 1'b1;
                           voice_note[4*free_idx +: 4]               <= code_note;
                           voice_octave[OCT_WIDTH*free_idx +: OCT_WIDTH] <= octave;
                           event_valid <= 1'b1;
                           event_on    <= 1'b1;
                           event_voice <= free_idx;
                        end else begin
                           overflow <= 1'b1;
                        end
                     end
                  end else if (code_is_ctrl && !ctrl_held[code_ctrl]) begin
                     ctrl_held[code_ctrl] <= 1'b1;
                     case (code_ctrl)
                        2'd0: if (octave != '0) octave <= octave - 1'b1;
                        2'd1: if (octave != {OCT_WIDTH{1'b1}}) octave <= octave + 1'b1;
                        2'd2: if (amplitude != '0) amplitude <= amplitude - 1'b1;
                        default: if (amplitude != {AMP_WIDTH{1'b1}}) amplitude <= amplitude + 1'b1;
                     endcase
                  end
               end
               S_BRK: begin
                  if (scan_code == CODE_BRK) begin
                     state <= S_BRK;
                  end else if (scan_code == CODE_EXT) begin
                     state <= S_EXT_BRK;
                  end else begin
                     state <= S_IDLE;
                     if (code_is_note && held_hit) begin
                        voice_active[held_idx] <= 1'b0;
                        event_valid <= 1'b1;
                        event_on    <= 1'b0;
                        event_voice <= held_idx;
                     end else if (code_is_ctrl) begin
                        ctrl_held[code_ctrl] <= 1'b0;
                     end
                  end
               end
               S_EXT: begin
                  state <= (scan_code == CODE_BRK) ? S_EXT_BRK : S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
